// File: rtl/lsu_apb_master.sv
// Load/store stage behind the 8-bit ALU. LW/SW become one APB3 transfer
// addressed by the ALU result; every other opcode forwards the ALU result
// unchanged, so all results leave through the single rsp_* port.
//
// Handshake: a request is taken on the rising edge where req_valid and
// req_ready are both 1. req_ready is 1 only in IDLE, and the upstream stage
// must hold req_valid and its payload until that edge. rsp_valid is a
// one-cycle pulse with no backpressure; rsp_data/rsp_err hold until the next
// response.
module lsu_apb_master #(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 15
) (
   input  logic              pclk,
   input  logic              presetn,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [2:0]        req_op,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] paddr,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [DATA_W-1:0] pwdata,
   input  logic [DATA_W-1:0] prdata,
   input  logic              pready,
   input  logic              pslverr,
   output logic [1:0]        dbg_state_o
);

   localparam logic [2:0] OP_LW = 3'b101;
   localparam logic [2:0] OP_SW = 3'b110;

   // Counter must be able to hold TIMEOUT itself.
   localparam int CNT_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   // Value the counter holds during the last allowed ACCESS cycle.
   localparam int TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [2:0]        op_q, op_d;
   logic [ADDR_W-1:0] paddr_q, paddr_d;
   logic              pwrite_q, pwrite_d;
   logic [DATA_W-1:0] pwdata_q, pwdata_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic              rsp_err_q, rsp_err_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              req_is_mem;

   assign req_is_mem = (req_op == OP_LW) || (req_op == OP_SW);

   // Handshake and APB phase strobes decode straight from the state, so an
   // asynchronous reset removes them in the same cycle.
   assign req_ready   = (state_q == IDLE);
   assign psel        = (state_q == SETUP) || (state_q == ACCESS);
   assign penable     = (state_q == ACCESS);
   assign rsp_valid   = (state_q == RESP);
   assign paddr       = paddr_q;
   assign pwrite      = pwrite_q;
   assign pwdata      = pwdata_q;
   assign rsp_data    = rsp_data_q;
   assign rsp_err     = rsp_err_q;
   assign dbg_state_o = state_q;

   // Next-state logic: request capture, APB sequencing, timeout and response.
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      paddr_d    = paddr_q;
      pwrite_d   = pwrite_q;
      pwdata_d   = pwdata_q;
      rsp_data_d = rsp_data_q;
      rsp_err_d  = rsp_err_q;
      cnt_d      = cnt_q;

      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               op_d = req_op;
               if (req_is_mem) begin
                  state_d  = SETUP;
                  paddr_d  = req_addr;
                  pwrite_d = (req_op == OP_SW);
                  pwdata_d = (req_op == OP_SW) ? req_wdata : '0;
                  cnt_d    = '0;
               end else begin
                  // ALU result forwarded as-is; BEQ's flag is not handled here.
                  state_d    = RESP;
                  rsp_data_d = DATA_W'(req_addr);
                  rsp_err_d  = 1'b0;
               end
            end
         end
         SETUP: begin
            state_d = ACCESS;
         end
         ACCESS: begin
            if (pready) begin
               // Completion wins even in the cycle the timeout would fire.
               state_d    = RESP;
               rsp_data_d = (op_q == OP_LW) ? prdata : '0;
               rsp_err_d  = pslverr;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               if ((TIMEOUT != 0) && (cnt_q == CNT_W'(TO_LAST))) begin
                  state_d    = RESP;
                  rsp_data_d = '0;
                  rsp_err_d  = 1'b1;
               end
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register; reset drops any in-flight request without a response.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state_q    <= IDLE;
         op_q       <= '0;
         paddr_q    <= '0;
         pwrite_q   <= 1'b0;
         pwdata_q   <= '0;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         paddr_q    <= paddr_d;
         pwrite_q   <= pwrite_d;
         pwdata_q   <= pwdata_d;
         rsp_data_q <= rsp_data_d;
         rsp_err_q  <= rsp_err_d;
         cnt_q      <= cnt_d;
      end
   end

endmodule

// File: tb/tb_lsu_apb_master.sv
// Bench for lsu_apb_master: directed scenarios plus randomized requests,
// checked against a transaction-level reference model (latency, response,
// APB activity and a reference memory image).
module tb_lsu_apb_master;

   localparam int ADDR_W  = 8;
   localparam int DATA_W  = 8;
   localparam int TIMEOUT = 15;
   localparam int NEVER   = 255;

   logic              pclk;
   logic              presetn;
   logic              req_valid;
   logic              req_ready;
   logic [2:0]        req_op;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_err;
   logic [ADDR_W-1:0] paddr;
   logic              psel;
   logic              penable;
   logic              pwrite;
   logic [DATA_W-1:0] pwdata;
   logic [DATA_W-1:0] prdata;
   logic              pready;
   logic              pslverr;
   logic [1:0]        dbg_state;

   int n_checks = 0;
   int n_errors = 0;

   // slave configuration and memories
   int                cfg_waits = 0;
   logic              cfg_err   = 1'b0;
   logic [DATA_W-1:0] slave_mem [256];
   logic [DATA_W-1:0] ref_mem   [256];
   logic [DATA_W:0]   exp_q [$];

   lsu_apb_master #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .pclk       (pclk),
      .presetn    (presetn),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_data   (rsp_data),
      .rsp_err    (rsp_err),
      .paddr      (paddr),
      .psel       (psel),
      .penable    (penable),
      .pwrite     (pwrite),
      .pwdata     (pwdata),
      .prdata     (prdata),
      .pready     (pready),
      .pslverr    (pslverr),
      .dbg_state_o(dbg_state)
   );

   // clock
   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // APB slave: ready after cfg_waits wait states in ACCESS, noise elsewhere
   initial begin
      int acc_n;
      acc_n   = 0;
      pready  = 1'b0;
      pslverr = 1'b0;
      prdata  = '0;
      forever begin
         @(negedge pclk);
         if (psel && penable) begin
            if (acc_n == cfg_waits) begin
               pready  = 1'b1;
               pslverr = cfg_err;
               if (pwrite) slave_mem[paddr] = pwdata;
               else        prdata = slave_mem[paddr];
            end else begin
               pready  = 1'b0;
               pslverr = $urandom_range(0, 1);
               prdata  = DATA_W'($urandom);
            end
            acc_n++;
         end else begin
            acc_n   = 0;
            pready  = $urandom_range(0, 1);
            pslverr = $urandom_range(0, 1);
            prdata  = DATA_W'($urandom);
         end
      end
   end

   // One request, called just after a negedge with the DUT idle.
   task automatic do_req(input logic [2:0] op, input logic [7:0] addr, input logic [7:0] wdata,
                         input int waits, input logic serr);
      logic              is_mem, is_sw, timed_out, got;
      logic [DATA_W-1:0] e_data, e_pwdata;
      logic              e_err;
      logic [DATA_W:0]   e;
      int                e_lat, e_psel, lat, psel_n, pen_n, bad;
      is_mem    = (op == 3'd5) || (op == 3'd6);
      is_sw     = (op == 3'd6);
      timed_out = is_mem && (waits >= TIMEOUT);
      e_pwdata  = is_sw ? wdata : 8'h00;
      if (!is_mem) begin
         e_lat = 1; e_psel = 0; e_data = addr; e_err = 1'b0;
      end else if (timed_out) begin
         e_lat = 2 + TIMEOUT; e_psel = 1 + TIMEOUT; e_data = 8'h00; e_err = 1'b1;
      end else begin
         e_lat  = 3 + waits;
         e_psel = 2 + waits;
         e_err  = serr;
         e_data = is_sw ? 8'h00 : ref_mem[addr];
         if (is_sw) ref_mem[addr] = wdata;
      end
      exp_q.push_back({e_err, e_data});

      cfg_waits = waits;
      cfg_err   = serr;
      check_eq("ready_idle", req_ready, 1);
      req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
      @(posedge pclk);
      #1;
      req_valid = 1'b0;
      req_op    = 3'($urandom);
      req_addr  = 8'($urandom);
      req_wdata = 8'($urandom);
      got = 1'b0; lat = 0; psel_n = 0; pen_n = 0; bad = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge pclk);
         if (psel) begin
            psel_n++;
            if (penable) pen_n++;
            else if (psel_n != 1) bad++;
            if (paddr !== addr || pwrite !== is_sw || pwdata !== e_pwdata) bad++;
         end else if (penable) begin
            bad++;
         end
         if (req_ready) bad++;
         if (rsp_valid) begin
            got = 1'b1;
            lat = k;
            break;
         end
      end
      e = exp_q.pop_front();
      check_eq("rsp_seen", got, 1);
      check_eq("latency", lat, e_lat);
      check_eq("psel_cycles", psel_n, e_psel);
      check_eq("penable_cycles", pen_n, (e_psel > 0) ? e_psel - 1 : 0);
      check_eq("apb_protocol", bad, 0);
      check_eq("rsp_data", rsp_data, e[DATA_W-1:0]);
      check_eq("rsp_err", rsp_err, e[DATA_W]);
      @(negedge pclk);
      check_eq("rsp_pulse", rsp_valid, 0);
      check_eq("rsp_hold", {rsp_err, rsp_data}, e);
   endtask

   initial begin
      int pulse_n, bad;
      int pulse_t [2];
      logic [7:0] pulse_d [2];
      logic [7:0] a;
      presetn = 1'b0; req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
      for (int i = 0; i < 256; i++) begin
         slave_mem[i] = 8'($urandom);
         ref_mem[i]   = slave_mem[i];
      end
      slave_mem[8'h3C] = 8'hA5;
      ref_mem[8'h3C]   = 8'hA5;

      // reset values
      #12;
      check_eq("rst_ready", req_ready, 1);
      check_eq("rst_apb", {psel, penable, pwrite}, 0);
      check_eq("rst_rsp", {rsp_valid, rsp_err}, 0);
      check_eq("rst_paddr", paddr, 0);
      check_eq("rst_pwdata", pwdata, 0);
      check_eq("rst_rsp_data", rsp_data, 0);
      check_eq("rst_state", dbg_state, 0);
      @(negedge pclk);
      presetn = 1'b1;
      @(negedge pclk);

      // directed scenarios
      do_req(3'd5, 8'h3C, 8'h00, 0, 1'b0);     // LW, zero wait
      check_eq("lw_a5", rsp_data, 8'hA5);
      do_req(3'd6, 8'h10, 8'h5A, 2, 1'b0);     // SW, two waits
      check_eq("sw_mem", slave_mem[8'h10], 8'h5A);
      do_req(3'd5, 8'h10, 8'h00, 1, 1'b1);     // LW with pslverr
      check_eq("lw_err_data", rsp_data, 8'h5A);
      do_req(3'd5, 8'h22, 8'h00, NEVER, 1'b0); // timeout
      do_req(3'd5, 8'h22, 8'h00, TIMEOUT - 1, 1'b0); // ready on last cycle

      // ADD then SUB with req_valid held
      req_valid = 1'b1; req_op = 3'd0; req_addr = 8'h7F;
      @(posedge pclk);
      #1;
      req_op = 3'd1; req_addr = 8'hFE;
      pulse_n = 0; bad = 0;
      pulse_t[0] = 0; pulse_t[1] = 0; pulse_d[0] = '0; pulse_d[1] = '0;
      for (int k = 1; k <= 5; k++) begin
         @(negedge pclk);
         if (psel || penable) bad++;
         if (k == 1) check_eq("ready_resp", req_ready, 0);
         if (rsp_valid) begin
            if (pulse_n < 2) begin
               pulse_t[pulse_n] = k;
               pulse_d[pulse_n] = rsp_data;
            end
            pulse_n++;
         end
         if (k == 3) req_valid = 1'b0;
      end
      check_eq("pt_pulses", pulse_n, 2);
      check_eq("pt_spacing", pulse_t[1] - pulse_t[0], 2);
      check_eq("pt_first", pulse_d[0], 8'h7F);
      check_eq("pt_second", pulse_d[1], 8'hFE);
      check_eq("pt_no_apb", bad, 0);

      // reset during ACCESS of a SW
      cfg_waits = NEVER;
      req_valid = 1'b1; req_op = 3'd6; req_addr = 8'h44; req_wdata = 8'hC3;
      @(posedge pclk);
      #1;
      req_valid = 1'b0;
      for (int k = 0; k < 4; k++) @(negedge pclk);
      check_eq("mid_access", {psel, penable, pwrite}, 3'b111);
      #2;
      presetn = 1'b0;
      #1;
      check_eq("rst_mid_apb", {psel, penable, pwrite}, 0);
      check_eq("rst_mid_rsp", rsp_valid, 0);
      check_eq("rst_mid_ready", req_ready, 1);
      @(negedge pclk);
      @(negedge pclk);
      presetn = 1'b1;
      bad = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge pclk);
         if (rsp_valid || psel) bad++;
      end
      check_eq("rst_no_rsp", bad, 0);
      do_req(3'd5, 8'h44, 8'h00, 0, 1'b0);     // sees pre-reset contents

      // randomized traffic
      for (int i = 0; i < 40; i++) begin
         int r, w;
         r = $urandom_range(0, 9);
         if (r < 6)      w = $urandom_range(0, 3);
         else if (r < 8) w = TIMEOUT - 1;
         else if (r < 9) w = NEVER;
         else            w = $urandom_range(4, TIMEOUT - 2);
         a = 8'($urandom);
         do_req(3'($urandom), a, 8'($urandom), w, ($urandom_range(0, 3) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // global guard against a hung run
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
